// File: rtl/step_controller.sv
// step_controller: run/halt/single-step controller turning slowCLK rises into one-cycle cpu_en pulses.
// Define STEP_COUNT_EN to implement the step_count pulse counter (tied to 0 otherwise).
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_W         = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               slowCLK,
    input  logic               run,
    input  logic               step_btn,
    input  logic               halt_req,
    output logic               cpu_en,
    output logic [1:0]         state,
    output logic [COUNT_W-1:0] step_count
);
    typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, WAIT_REL = 2'b11} state_t;

    state_t      cur, nxt;
    logic        slow_s1, slow_s2, slow_prev;
    logic        btn_s1, btn_s2;
    logic        db_lvl, db_prev;
    logic [15:0] db_cnt;
    logic        tick, step_req, en_nxt;

    assign state    = cur;
    assign tick     = slow_s2 & ~slow_prev;
    assign step_req = db_lvl & ~db_prev;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            {slow_s1, slow_s2, slow_prev} <= '0;
            {btn_s1, btn_s2}              <= '0;
        end else begin
            slow_s1   <= slowCLK;
            slow_s2   <= slow_s1;
            slow_prev <= slow_s2;
            btn_s1    <= step_btn;
            btn_s2    <= btn_s1;
        end
    end

    // counter only runs while the synchronized button disagrees with the debounced level
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            db_lvl  <= 1'b0;
            db_prev <= 1'b0;
            db_cnt  <= '0;
        end else begin
            db_prev <= db_lvl;
            if (btn_s2 == db_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
                db_lvl <= btn_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cur <= HALT;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            HALT:     nxt = (run && !halt_req) ? RUN : step_req ? STEP : HALT;
            RUN:      nxt = (halt_req || !run) ? HALT : RUN;
            STEP:     nxt = tick ? WAIT_REL : STEP;
            WAIT_REL: nxt = db_lvl ? WAIT_REL : HALT;
            default:  nxt = HALT;
        endcase
    end

    always_comb begin
        en_nxt = ((cur == RUN) && tick && run && !halt_req) || ((cur == STEP) && tick);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cpu_en <= 1'b0;
        else        cpu_en <= en_nxt;
    end

`ifdef STEP_COUNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)      step_count <= '0;
        else if (cpu_en) step_count <= step_count + COUNT_W'(1);
    end
`else
    assign step_count = '0;
`endif
endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: scoreboard bench; expected cpu_en pulse cycles are queued as slowCLK rises are driven.
module tb_step_controller;
    logic       CLK = 1'b0, RST_N = 1'b0, slowCLK = 1'b0, run = 1'b0, step_btn = 1'b0, halt_req = 1'b0;
    logic       cpu_en;
    logic [1:0] state;
    logic [3:0] step_count;
    int         cyc = 0, n_chk = 0, n_pass = 0, n_pulse = 0, n_step_entry = 0, p0;
    int         exp_q[$];
    logic [1:0] prev_state = 2'b00;

    step_controller #(.DEBOUNCE_CYCLES(16), .COUNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .slowCLK(slowCLK), .run(run), .step_btn(step_btn),
        .halt_req(halt_req), .cpu_en(cpu_en), .state(state), .step_count(step_count)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int exp_cnt(input int n);
`ifdef STEP_COUNT_EN
        return n % 16;
`else
        return 0 * n;
`endif
    endfunction

    // pops the scoreboard whenever the DUT issues a pulse
    always @(posedge CLK) begin
        #1;
        if (cpu_en) begin
            n_pulse++;
            if (exp_q.size() == 0) check("unexpected_pulse_cycle", cyc, -1);
            else check("pulse_cycle", cyc, exp_q.pop_front());
        end
        if (state == 2'b10 && prev_state != 2'b10) n_step_entry++;
        prev_state = state;
    end

    task automatic slow_periods(input int n, input int n_expect);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            slowCLK = 1'b1;
            if (i < n_expect) exp_q.push_back(cyc + 3);
            repeat (4) @(negedge CLK);
            slowCLK = 1'b0;
            repeat (3) @(negedge CLK);
        end
        repeat (2) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        bit seen;
        run = 1'b1;
        repeat (5) @(negedge CLK);
        check("rst_state", state, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_count", step_count, 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check("run_entry_state", state, 1);
        slow_periods(10, 10);
        check("run_pulses", n_pulse, 10);
        check("run_count", step_count, exp_cnt(10));

        // halt_req coincides with the tick cycle
        @(negedge CLK);
        slowCLK = 1'b1;
        k = cyc;
        repeat (2) @(negedge CLK);
        check("tick_cycle_align", cyc, k + 2);
        halt_req = 1'b1;
        @(posedge CLK); #1;
        check("halt_prio_state", state, 0);
        check("halt_prio_en", cpu_en, 0);
        @(negedge CLK);
        halt_req = 1'b0;
        run = 1'b0;
        repeat (3) @(negedge CLK);
        slowCLK = 1'b0;
        repeat (4) @(negedge CLK);
        check("halt_prio_pulses", n_pulse, 10);
        check("halt_prio_count", step_count, exp_cnt(10));
        check("halt_stays", state, 0);

        // bouncy press: five toggles three cycles apart, then a clean hold
        p0 = n_pulse;
        for (int i = 0; i < 5; i++) begin
            step_btn = ~step_btn;
            repeat (3) @(negedge CLK);
        end
        repeat (40) @(negedge CLK);
        check("bounce_step_state", state, 2);
        check("bounce_step_entries", n_step_entry, 1);
        slow_periods(1, 1);
        check("bounce_wait_rel", state, 3);
        slow_periods(1, 0);
        check("bounce_still_wait", state, 3);
        step_btn = 1'b0;
        repeat (25) @(negedge CLK);
        check("bounce_release", state, 0);
        check("bounce_pulses", n_pulse - p0, 1);
        check("bounce_step_entries_end", n_step_entry, 1);

        // held button spans several slow periods
        p0 = n_pulse;
        step_btn = 1'b1;
        repeat (25) @(negedge CLK);
        check("held_step_state", state, 2);
        slow_periods(5, 1);
        check("held_wait_rel", state, 3);
        step_btn = 1'b0;
        repeat (25) @(negedge CLK);
        check("held_release", state, 0);
        check("held_pulses", n_pulse - p0, 1);
        check("held_count", step_count, exp_cnt(12));

        // asynchronous reset while cpu_en is high
        run = 1'b1;
        @(negedge CLK);
        check("mid_rst_run", state, 1);
        slowCLK = 1'b1;
        exp_q.push_back(cyc + 3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge CLK); #1;
            seen = cpu_en;
        end
        check("mid_rst_pulse_seen", seen, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_cpu_en", cpu_en, 0);
        check("mid_rst_state", state, 0);
        check("mid_rst_count", step_count, 0);
        run = 1'b0;
        slowCLK = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        check("post_rst_state", state, 0);

        // counter wrap: 17 pulses from zero
        run = 1'b1;
        repeat (2) @(negedge CLK);
        slow_periods(17, 17);
        check("wrap_count", step_count, exp_cnt(17));
        run = 1'b0;
        repeat (4) @(negedge CLK);
        check("final_state", state, 0);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
